// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer with one registered
// output stage. Each transfer is arbitrated by fixed priority (lowest index
// wins) or by round-robin starting at ptr; rr_mode selects between the two.
module rr_stream_mux #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]      out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] ptr_next;
  logic [SEL_WIDTH-1:0] fixed_grant;
  logic [SEL_WIDTH-1:0] rr_grant;
  logic [SEL_WIDTH-1:0] grant;
  logic                 any_valid;
  logic                 load_en;
  logic                 in_xfer;
  logic                 out_xfer;

  // The output register can take a word when empty or draining this cycle.
  assign load_en   = ~out_valid | out_ready;
  assign any_valid = |in_valid;
  assign in_xfer   = any_valid & load_en & ~rst;
  assign out_xfer  = out_valid & out_ready;

  // Fixed priority: scan from the top down so the lowest valid index wins.
  always_comb begin
    fixed_grant = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fixed_grant = SEL_WIDTH'(i);
      end
    end
  end

  // Round-robin: first valid channel at or after ptr, wrapping at CHANNELS.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    rr_grant = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!found && in_valid[idx]) begin
        found    = 1'b1;
        rr_grant = SEL_WIDTH'(idx);
      end
    end
  end

  assign grant = rr_mode ? rr_grant : fixed_grant;

  // Pointer advances past the granted channel, wrapping from CHANNELS-1 to 0.
  always_comb begin
    if (grant == SEL_WIDTH'(CHANNELS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant + SEL_WIDTH'(1);
    end
  end

  // One-hot ready to the granted channel only when the output can load.
  always_comb begin
    in_ready = '0;
    if (in_xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_sel   <= grant;
      ptr       <= ptr_next;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
